// File: rtl/csr_reg_file.sv
// Machine-mode CSR register file: commits WB-stage CSR writes, serves EX-stage reads with
// write-through bypass, and owns the 64-bit mcycle/minstret counters.
module csr_reg_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we_WB,
  input  logic [11:0] csr_addr_WB,
  input  logic [31:0] csr_data_WB,
  input  logic        instret_inc,
  input  logic [11:0] csr_raddr_EX,
  output logic [31:0] csr_rdata_EX,
  output logic        csr_hit_EX,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMinstreth = 12'hB82;
  localparam logic [11:0] AddrCycle     = 12'hC00;
  localparam logic [11:0] AddrCycleh    = 12'hC80;
  localparam logic [11:0] AddrInstret   = 12'hC02;
  localparam logic [11:0] AddrInstreth  = 12'hC82;
  localparam logic [11:0] AddrMhartid   = 12'hF14;

  // Only MIE (bit 3) and MPIE (bit 7) are implemented in mstatus.
  localparam logic [31:0] MstatusMask = 32'h0000_0088;
  localparam logic [31:0] AlignMask   = 32'hFFFF_FFFC;

  logic [31:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q, mcycle_d, mcycle_inc;
  logic [63:0] minstret_q, minstret_d, minstret_inc;

  logic        wr_writable;
  logic        wr_en;
  logic [31:0] wdata_masked;

  // Decode the WB write: which addresses accept writes and how their data is masked.
  always_comb begin
    wr_writable  = 1'b0;
    wdata_masked = csr_data_WB;
    case (csr_addr_WB)
      AddrMstatus: begin
        wr_writable  = 1'b1;
        wdata_masked = csr_data_WB & MstatusMask;
      end
      AddrMtvec, AddrMepc: begin
        wr_writable  = 1'b1;
        wdata_masked = csr_data_WB & AlignMask;
      end
      AddrMscratch, AddrMcause, AddrMcycle, AddrMcycleh, AddrMinstret, AddrMinstreth: begin
        wr_writable = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_en = csr_we_WB & wr_writable;

  // A written counter half takes the write data; the other half keeps its increment/carry.
  always_comb begin
    mcycle_inc   = mcycle_q + 64'd1;
    minstret_inc = minstret_q + {63'd0, instret_inc};
    mcycle_d     = mcycle_inc;
    minstret_d   = minstret_inc;
    if (wr_en) begin
      case (csr_addr_WB)
        AddrMcycle:    mcycle_d[31:0]    = wdata_masked;
        AddrMcycleh:   mcycle_d[63:32]   = wdata_masked;
        AddrMinstret:  minstret_d[31:0]  = wdata_masked;
        AddrMinstreth: minstret_d[63:32] = wdata_masked;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= 32'd0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      if (wr_en && csr_addr_WB == AddrMstatus)  mstatus_q  <= wdata_masked;
      if (wr_en && csr_addr_WB == AddrMtvec)    mtvec_q    <= wdata_masked;
      if (wr_en && csr_addr_WB == AddrMscratch) mscratch_q <= wdata_masked;
      if (wr_en && csr_addr_WB == AddrMepc)     mepc_q     <= wdata_masked;
      if (wr_en && csr_addr_WB == AddrMcause)   mcause_q   <= wdata_masked;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  always_comb begin
    csr_hit_EX   = 1'b1;
    csr_rdata_EX = 32'd0;
    case (csr_raddr_EX)
      AddrMstatus:                 csr_rdata_EX = mstatus_q;
      AddrMtvec:                   csr_rdata_EX = mtvec_q;
      AddrMscratch:                csr_rdata_EX = mscratch_q;
      AddrMepc:                    csr_rdata_EX = mepc_q;
      AddrMcause:                  csr_rdata_EX = mcause_q;
      AddrMcycle,    AddrCycle:    csr_rdata_EX = mcycle_q[31:0];
      AddrMcycleh,   AddrCycleh:   csr_rdata_EX = mcycle_q[63:32];
      AddrMinstret,  AddrInstret:  csr_rdata_EX = minstret_q[31:0];
      AddrMinstreth, AddrInstreth: csr_rdata_EX = minstret_q[63:32];
      AddrMhartid:                 csr_rdata_EX = MHARTID;
      default:                     csr_hit_EX   = 1'b0;
    endcase
    // Same-address bypass only; read-only aliases never match a writable write address.
    if (wr_en && csr_addr_WB == csr_raddr_EX) csr_rdata_EX = wdata_masked;
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_reg_file.sv
// Randomized self-checking bench for csr_reg_file against a behavioural CSR model.
module tb_csr_reg_file;

  localparam logic [31:0] MtvecRst = 32'h0000_0100;
  localparam logic [31:0] HartId   = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst, csr_we_WB, instret_inc;
  logic [11:0] csr_addr_WB, csr_raddr_EX;
  logic [31:0] csr_data_WB, csr_rdata_EX, mtvec_o, mepc_o;
  logic        csr_hit_EX;

  int checks = 0;
  int errors = 0;

  // Model state: plain named registers and 64-bit counters.
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  csr_reg_file #(
    .MTVEC_RESET(MtvecRst),
    .MHARTID    (HartId)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_we_WB   (csr_we_WB),
    .csr_addr_WB (csr_addr_WB),
    .csr_data_WB (csr_data_WB),
    .instret_inc (instret_inc),
    .csr_raddr_EX(csr_raddr_EX),
    .csr_rdata_EX(csr_rdata_EX),
    .csr_hit_EX  (csr_hit_EX),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o)
  );

  always #5 clk = ~clk;

  // {writable, value actually stored} for a write of wd to address a.
  function automatic logic [32:0] wr_view(input logic [11:0] a, input logic [31:0] wd);
    case (a)
      12'h300:                            return {1'b1, wd & 32'h88};
      12'h305, 12'h341:                   return {1'b1, wd & 32'hFFFF_FFFC};
      12'h340, 12'h342, 12'hB00, 12'hB80,
      12'hB02, 12'hB82:                   return {1'b1, wd};
      default:                            return {1'b0, 32'd0};
    endcase
  endfunction

  // {hit, data} expected on the read port for the current inputs.
  function automatic logic [32:0] exp_read(input logic [11:0] ra);
    logic [32:0] w;
    w = wr_view(csr_addr_WB, csr_data_WB);
    if (csr_we_WB && w[32] && csr_addr_WB == ra) return {1'b1, w[31:0]};
    case (ra)
      12'h300:          return {1'b1, m_mstatus};
      12'h305:          return {1'b1, m_mtvec};
      12'h340:          return {1'b1, m_mscratch};
      12'h341:          return {1'b1, m_mepc};
      12'h342:          return {1'b1, m_mcause};
      12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
      12'hF14:          return {1'b1, HartId};
      default:          return {1'b0, 32'd0};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs away from the active edge, then compare every output against the model.
  task automatic drive(input logic r, input logic we, input logic [11:0] wa,
                       input logic [31:0] wd, input logic inc, input logic [11:0] ra);
    logic [32:0] e;
    @(negedge clk);
    rst = r; csr_we_WB = we; csr_addr_WB = wa; csr_data_WB = wd;
    instret_inc = inc; csr_raddr_EX = ra;
    #1;
    e = exp_read(ra);
    chk("rdata", {32'd0, csr_rdata_EX}, {32'd0, e[31:0]});
    chk("hit", {63'd0, csr_hit_EX}, {63'd0, e[32]});
    chk("mtvec_o", {32'd0, mtvec_o}, {32'd0, m_mtvec});
    chk("mepc_o", {32'd0, mepc_o}, {32'd0, m_mepc});
  endtask

  // Clock edge: advance the model using the inputs held across it.
  task automatic tick();
    logic [63:0] cyc_n, ins_n;
    logic [32:0] w;
    @(posedge clk);
    if (rst) begin
      m_mstatus = 0; m_mtvec = MtvecRst; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_cyc = 0; m_ins = 0;
    end else begin
      cyc_n = m_cyc + 64'd1;
      ins_n = m_ins + (instret_inc ? 64'd1 : 64'd0);
      w = wr_view(csr_addr_WB, csr_data_WB);
      if (csr_we_WB && w[32]) begin
        case (csr_addr_WB)
          12'h300: m_mstatus  = w[31:0];
          12'h305: m_mtvec    = w[31:0];
          12'h340: m_mscratch = w[31:0];
          12'h341: m_mepc     = w[31:0];
          12'h342: m_mcause   = w[31:0];
          12'hB00: cyc_n[31:0]  = w[31:0];
          12'hB80: cyc_n[63:32] = w[31:0];
          12'hB02: ins_n[31:0]  = w[31:0];
          12'hB82: ins_n[63:32] = w[31:0];
          default: ;
        endcase
      end
      m_cyc = cyc_n;
      m_ins = ins_n;
    end
  endtask

  logic [11:0] addr_tbl [18] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                 12'hC82, 12'hF14, 12'h000, 12'h7C0, 12'h301, 12'hB01};

  function automatic logic [11:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 12'($urandom);
    return addr_tbl[$urandom_range(0, 17)];
  endfunction

  initial begin
    m_mstatus = 'x; m_mtvec = 'x; m_mscratch = 'x; m_mepc = 'x; m_mcause = 'x;
    m_cyc = 'x; m_ins = 'x;
    rst = 1; csr_we_WB = 0; csr_addr_WB = 0; csr_data_WB = 0; instret_inc = 0; csr_raddr_EX = 0;
    @(posedge clk); tick();
    m_cyc = 0;  // defined after the first reset edge; the model is now fully known
    drive(1, 0, 12'h000, 0, 0, 12'hB00); tick();

    // Reset values and cycle count after release.
    drive(0, 0, 12'h000, 0, 0, 12'hB00);
    chk("rst_mtvec", {32'd0, mtvec_o}, 64'h100);
    chk("rst_mepc", {32'd0, mepc_o}, 64'h0);
    chk("rst_mcycle", {32'd0, csr_rdata_EX}, 64'h0);
    tick();
    drive(0, 0, 12'h000, 0, 0, 12'hB00); tick();
    drive(0, 0, 12'h000, 0, 0, 12'hB00);
    chk("mcycle_after_2", {32'd0, csr_rdata_EX}, 64'd2);
    tick();

    // Bypass and masking.
    drive(0, 1, 12'h340, 32'hDEADBEEF, 0, 12'h340);
    chk("mscratch_bypass", {32'd0, csr_rdata_EX}, 64'hDEADBEEF);
    tick();
    drive(0, 0, 12'h000, 0, 0, 12'h340);
    chk("mscratch_reg", {32'd0, csr_rdata_EX}, 64'hDEADBEEF);
    tick();
    drive(0, 1, 12'h341, 32'h1237, 0, 12'h341);
    chk("mepc_bypass", {32'd0, csr_rdata_EX}, 64'h1234);
    chk("mepc_o_nobypass", {32'd0, mepc_o}, 64'h0);
    tick();
    drive(0, 1, 12'h300, 32'hFFFF_FFFF, 0, 12'h000);
    chk("mepc_o", {32'd0, mepc_o}, 64'h1234);
    tick();
    drive(0, 0, 12'h000, 0, 0, 12'h300);
    chk("mstatus_mask", {32'd0, csr_rdata_EX}, 64'h88);
    tick();

    // mcycle carry from low to high word.
    drive(0, 1, 12'hB00, 32'hFFFF_FFFE, 0, 12'h000); tick();
    drive(0, 1, 12'hB80, 32'h0, 0, 12'h000); tick();
    drive(0, 0, 12'h000, 0, 0, 12'hB80);
    chk("mcycleh_pre", {32'd0, csr_rdata_EX}, 64'h0);
    tick();
    drive(0, 0, 12'h000, 0, 0, 12'hB80);
    chk("mcycleh_carry", {32'd0, csr_rdata_EX}, 64'h1);
    tick();

    // minstret counting and write-wins.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 12'h000, 0, 1, 12'hC02); tick();
    end
    drive(0, 0, 12'h000, 0, 0, 12'hC02);
    chk("instret_5", {32'd0, csr_rdata_EX}, 64'd5);
    tick();
    drive(0, 1, 12'hB02, 32'd10, 1, 12'hB02); tick();
    drive(0, 0, 12'h000, 0, 0, 12'hB02);
    chk("minstret_write_wins", {32'd0, csr_rdata_EX}, 64'd10);
    tick();

    // Ignored writes and unimplemented reads.
    drive(0, 1, 12'hC00, 32'd5, 0, 12'hC00); tick();
    drive(0, 1, 12'h000, 32'd7, 0, 12'h7C0);
    chk("unimpl_rdata", {32'd0, csr_rdata_EX}, 64'h0);
    chk("unimpl_hit", {63'd0, csr_hit_EX}, 64'h0);
    tick();
    drive(0, 0, 12'h000, 0, 0, 12'hF14);
    chk("mhartid", {32'd0, csr_rdata_EX}, 64'h5);
    chk("mhartid_hit", {63'd0, csr_hit_EX}, 64'h1);
    tick();

    // Random traffic, with near-wrap data to exercise counter carries.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      drive(($urandom_range(0, 60) == 0), $urandom_range(0, 1) == 1, pick_addr(), wd,
            $urandom_range(0, 1) == 1, pick_addr());
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
